reg_disp_scanner: RTL and testbench
===================================

Name: reg_disp_scanner

Overview:
Initiator side of the processor's diagnostic register-read port (dispSel out, dispDat in). Selects a register-file entry manually or by auto-stepping, captures the word through a small handshake FSM, and multiplexes 16 bits of it onto the Nexys2 4-digit seven-segment display. It sits at board top level between the mips instance and the display pins.

Parameters:
TICK_DIV, 10000, clk cycles per digit refresh step (50 MHz / 10000 = 5 kHz).
AUTO_PERIOD, 50000000, clk cycles the display stays on each register in auto mode.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
auto_en  in  1  1 = auto-step registers; 0 = manual
sel_man  in  5  register index used in manual mode
half_sel  in  1  0 = show dispDat[15:0]; 1 = show dispDat[31:16]
freeze  in  1  1 = hold the captured word and stop re-sampling
dispDat  in  32  register-file diagnostic read data (combinational from dispSel)
dispSel  out  5  register-file diagnostic read address (registered)
seg  out  7  segments, active low; seg[6]=g … seg[0]=a
an  out  4  digit anodes, active low; an[0] = rightmost digit
dp  out  1  decimal point, active low

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high. Reset values: dispSel=0, an=4'b1111, seg=7'b1111111, dp=1, shadow=0, digit index=0, refresh and dwell counters=0, FSM=S_SEL.
- Pointer, manual mode: ptr <= sel_man every cycle.
- Pointer, auto mode: the dwell counter counts 0..AUTO_PERIOD-1. At terminal count, ptr increments and the counter returns to 0. ptr wraps 31→0.
- Mode switch, manual→auto: ptr continues from its current value and the dwell counter clears.
- Mode switch, auto→manual: ptr = sel_man on the next cycle.
- dispSel = ptr, registered, so it changes 1 cycle after ptr.
- Capture FSM sequence: S_SEL (drive dispSel) → S_SETTLE (one cycle of settling) → S_CAP (shadow <= dispDat) → S_HOLD.
- Capture latency: 3 cycles from a ptr change to shadow update.
- Leaving S_HOLD: go to S_SEL when ptr changes, or when the digit index wraps 3→0. The wrap case re-samples live register contents once per full scan.
- Abort: a ptr change in any state other than S_HOLD restarts the FSM at S_SEL. The shadow must never take a word read under a stale dispSel.
- freeze=1: the FSM holds in S_HOLD (or stays there once reached) and shadow is unchanged. Scanning continues. On release, normal re-sampling resumes.
- Refresh: the refresh counter counts 0..TICK_DIV-1. At terminal count the digit index advances 0→1→2→3→0.
- Display outputs are registered and computed each cycle from the digit index and shadow:
  - an = ~(1<<idx).
  - Nibble shown = shadow[16*half_sel + 4*idx +: 4].
  - dp = 0 only when idx=3 and half_sel=1; otherwise dp = 1.
- Display timing: the first valid an/seg appears 1 cycle after reset deasserts (an=4'b1110).
- Hex to segment codes (g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Reset asserted mid-capture or mid-scan returns everything to the reset values on the next edge.

Optional Feature:
DISP_LZ_BLANK_EN.
- Defined: leading-zero digits of the displayed half are blanked (seg=7'b1111111, an still driven). Digit 0 is never blanked. Example: 0x0042 shows blank, blank, 4, 2.
- Undefined: all four digits are always shown.

Decomposition:
- Shared package reg_disp_pkg:
  - FSM state enum (S_SEL, S_SETTLE, S_CAP, S_HOLD).
  - SEG_BLANK constant.
  - The 16-entry segment code constants.
  - Digit count constant (4).
- One sub-module: hex_to_7seg (4-bit nibble in, 7-bit active-low segments out, combinational), instantiated once.
- Counters and the FSM live in reg_disp_scanner.

Test Plan:
All scenarios use TICK_DIV=4 and AUTO_PERIOD=16. The bench model returns dispDat = 32'h1234_ABCD when dispSel==5, and {27'h0, dispSel} otherwise.
1. Reset held 2 cycles → dispSel=0, an=1111, seg=1111111, dp=1. One cycle after release → an=1110.
2. auto_en=0, sel_man=5, half_sel=0 → dispSel=5 after 1 cycle and shadow=1234ABCD within 4 cycles. Then an=1110 gives seg=0100001 (d), and an=0111 gives seg=0001000 (A).
3. Same setup with half_sel=1 → an=0111 gives seg=1111001 (1) with dp=0; an=1110 gives seg=0011001 (4) with dp=1.
4. auto_en=1 starting from ptr=30 → dispSel steps to 31 after 16 cycles, then to 0 after 32 cycles. Each displayed word equals its index (ptr 31 shows 001F).
5. freeze=1, then the model changes reg 5 to 32'hDEAD_BEEF → display stays ABCD for at least 3 full scans. After freeze=0, it shows BEEF within one scan (16 cycles) + 3 cycles.
6. sel_man changes 5→7 while the FSM is in S_SETTLE → shadow never holds 1234ABCD afterward and ends at 0x00000007. With DISP_LZ_BLANK_EN defined, digits 3..1 are blank and digit 0 shows 7 (1111000).

Source files
------------

// File: rtl/reg_disp_pkg.sv
// Shared types and constants for the diagnostic register-display scanner:
// capture FSM states, seven-segment codes and digit geometry.
package reg_disp_pkg;

  typedef enum logic [1:0] {
    S_SEL,
    S_SETTLE,
    S_CAP,
    S_HOLD
  } state_t;

  localparam int NUM_DIGITS = 4;
  localparam int IDX_W      = $clog2(NUM_DIGITS);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low segment codes, bit order g..a, indexed by hex value.
  localparam logic [6:0] SEG_HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment decoder (g..a).
module hex_to_7seg
  import reg_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_HEX[nibble];

endmodule

// File: rtl/reg_disp_scanner.sv
// Diagnostic register-read initiator: selects a register, captures it through a
// small handshake FSM and scans 16 bits onto a 4-digit display.
// Optional: define DISP_LZ_BLANK_EN to blank leading-zero digits.
module reg_disp_scanner #(
  parameter int TICK_DIV    = 10000,
  parameter int AUTO_PERIOD = 50000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        auto_en,
  input  logic [4:0]  sel_man,
  input  logic        half_sel,
  input  logic        freeze,
  input  logic [31:0] dispDat,
  output logic [4:0]  dispSel,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp
);

  import reg_disp_pkg::*;

  localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DWELL_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(AUTO_PERIOD - 1);

  logic [4:0]         ptr, ptr_nxt;
  logic [DWELL_W-1:0] dwell, dwell_nxt;
  logic [TICK_W-1:0]  refresh;
  logic [IDX_W-1:0]   idx;
  state_t             state;
  logic [31:0]        shadow;
  logic               ptr_chg, tick, scan_wrap, blank;
  logic [3:0]         nibble;
  logic [6:0]         seg_code;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    ptr_nxt   = ptr;
    dwell_nxt = dwell;
    if (!auto_en) begin
      ptr_nxt   = sel_man;
      dwell_nxt = '0;
    end else if (dwell == DWELL_LAST) begin
      ptr_nxt   = ptr + 5'd1;
      dwell_nxt = '0;
    end else begin
      dwell_nxt = dwell + 1'b1;
    end
  end

  // Looking at the next pointer lets the FSM restart on the same edge ptr moves.
  assign ptr_chg   = (ptr_nxt != ptr);
  assign tick      = (refresh == TICK_LAST);
  assign scan_wrap = tick && (idx == IDX_W'(NUM_DIGITS - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr     <= '0;
      dwell   <= '0;
      dispSel <= '0;
      refresh <= '0;
      idx     <= '0;
    end else begin
      ptr     <= ptr_nxt;
      dwell   <= dwell_nxt;
      dispSel <= ptr;
      refresh <= tick ? '0 : refresh + 1'b1;
      if (tick) idx <= idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_SEL;
      shadow <= '0;
    end else if (ptr_chg && !(state == S_HOLD && freeze)) begin
      state <= S_SEL;
    end else begin
      case (state)
        S_SEL:    state <= S_SETTLE;
        S_SETTLE: state <= S_CAP;
        S_CAP: begin
          shadow <= dispDat;
          state  <= S_HOLD;
        end
        S_HOLD:   if (!freeze && scan_wrap) state <= S_SEL;
      endcase
    end
  end

  assign nibble = shadow[{half_sel, idx, 2'b00} +: 4];

  hex_to_7seg u_hex (
    .nibble (nibble),
    .seg    (seg_code)
  );

`ifdef DISP_LZ_BLANK_EN
  logic [15:0] half;
  assign half = half_sel ? shadow[31:16] : shadow[15:0];

  // A digit is blank when it and everything to its left is zero; digit 0 never.
  always_comb begin
    blank = 1'b0;
    case (idx)
      2'd1:    blank = (half[15:4]  == 12'h000);
      2'd2:    blank = (half[15:8]  == 8'h00);
      2'd3:    blank = (half[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= ~(4'b0001 << idx);
      seg <= blank ? SEG_BLANK : seg_code;
      dp  <= !((idx == 2'd3) && half_sel);
    end
  end

endmodule

// File: tb/tb_reg_disp_scanner.sv
// Scoreboard bench for reg_disp_scanner: stimulus queues expected digits, a
// monitor pops and compares them as the display scans past each digit.
module tb_reg_disp_scanner;

  logic        clk;
  logic        reset;
  logic        auto_en;
  logic [4:0]  sel_man;
  logic        half_sel;
  logic        freeze;
  logic [31:0] dispDat;
  logic [4:0]  dispSel;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;

  logic [31:0] reg5;
  int unsigned cyc;
  int          checks;
  int          errors;
  bit          stale_watch;
  int          stale_hits;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    string      name;
  } exp_t;

  exp_t sb[$];

`ifdef DISP_LZ_BLANK_EN
  localparam logic [6:0] LZ_ZERO = 7'b1111111;
`else
  localparam logic [6:0] LZ_ZERO = 7'b1000000;
`endif

  reg_disp_scanner #(
    .TICK_DIV    (4),
    .AUTO_PERIOD (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .auto_en  (auto_en),
    .sel_man  (sel_man),
    .half_sel (half_sel),
    .freeze   (freeze),
    .dispDat  (dispDat),
    .dispSel  (dispSel),
    .seg      (seg),
    .an       (an),
    .dp       (dp)
  );

  // Register-file model
  always_comb dispDat = (dispSel == 5'd5) ? reg5 : {27'h0, dispSel};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    stale_hits = 0;
    forever begin
      @(negedge clk);
      if (stale_watch && dut.shadow == 32'h1234ABCD) stale_hits++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic expect_digit(input int d, input logic [6:0] s, input logic p, input string name);
    exp_t e;
    e.an   = ~(4'b0001 << d);
    e.seg  = s;
    e.dp   = p;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic drain(input int budget, input string tag);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      check({tag, "_timeout_pending"}, sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic wait_cyc(input int unsigned target);
    while (cyc < target) @(negedge clk);
  endtask

  // Monitor: compare whenever the display presents the anode the queue expects
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0 && an === sb[0].an) begin
        e = sb.pop_front();
        check({e.name, "_seg"}, seg, e.seg);
        check({e.name, "_dp"}, dp, e.dp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned start;
    checks      = 0;
    errors      = 0;
    stale_watch = 1'b0;
    reset    = 1'b1;
    auto_en  = 1'b0;
    sel_man  = 5'd0;
    half_sel = 1'b0;
    freeze   = 1'b0;
    reg5     = 32'h1234ABCD;

    // Reset held two cycles
    repeat (2) @(negedge clk);
    check("rst_dispsel", dispSel, 5'd0);
    check("rst_an", an, 4'b1111);
    check("rst_seg", seg, 7'b1111111);
    check("rst_dp", dp, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    check("first_an", an, 4'b1110);
    check("first_seg", seg, 7'b1000000);

    // Manual select of reg 5, low half
    sel_man = 5'd5;
    repeat (2) @(negedge clk);
    check("man_dispsel", dispSel, 5'd5);
    repeat (4) @(negedge clk);
    expect_digit(0, 7'b0100001, 1'b1, "lo_d0_d");
    expect_digit(1, 7'b1000110, 1'b1, "lo_d1_C");
    expect_digit(2, 7'b0000011, 1'b1, "lo_d2_b");
    expect_digit(3, 7'b0001000, 1'b1, "lo_d3_A");
    drain(24, "lo");

    // High half with decimal point on digit 3
    half_sel = 1'b1;
    repeat (2) @(negedge clk);
    expect_digit(3, 7'b1111001, 1'b0, "hi_d3_1");
    expect_digit(0, 7'b0011001, 1'b1, "hi_d0_4");
    expect_digit(1, 7'b0110000, 1'b1, "hi_d1_3");
    expect_digit(2, 7'b0100100, 1'b1, "hi_d2_2");
    drain(24, "hi");

    // Manual 30, then auto stepping 30 -> 31 -> 0
    half_sel = 1'b0;
    sel_man  = 5'd30;
    repeat (6) @(negedge clk);
    expect_digit(0, 7'b0000110, 1'b1, "r30_d0_E");
    expect_digit(1, 7'b1111001, 1'b1, "r30_d1_1");
    drain(24, "r30");
    auto_en = 1'b1;
    start   = cyc;
    wait_cyc(start + 17);
    check("auto_dispsel_31", dispSel, 5'd31);
    wait_cyc(start + 20);
    expect_digit(0, 7'b0001110, 1'b1, "r31_d0_F");
    drain(15, "r31");
    wait_cyc(start + 34);
    check("auto_dispsel_wrap0", dispSel, 5'd0);

    // Freeze holds the captured word while reg 5 changes underneath
    auto_en = 1'b0;
    sel_man = 5'd5;
    repeat (6) @(negedge clk);
    freeze = 1'b1;
    repeat (2) @(negedge clk);
    reg5 = 32'hDEADBEEF;
    for (int s = 0; s < 3; s++) begin
      expect_digit(0, 7'b0100001, 1'b1, "frz_d0_d");
      expect_digit(1, 7'b1000110, 1'b1, "frz_d1_C");
      expect_digit(2, 7'b0000011, 1'b1, "frz_d2_b");
      expect_digit(3, 7'b0001000, 1'b1, "frz_d3_A");
    end
    drain(80, "frz");
    freeze = 1'b0;
    repeat (20) @(negedge clk);
    expect_digit(0, 7'b0001110, 1'b1, "thaw_d0_F");
    expect_digit(1, 7'b0000110, 1'b1, "thaw_d1_E");
    expect_digit(2, 7'b0000110, 1'b1, "thaw_d2_E");
    expect_digit(3, 7'b0000011, 1'b1, "thaw_d3_b");
    drain(24, "thaw");

    // Abort: sel_man moves 5 -> 7 while the FSM is settling on reg 5
    reg5    = 32'h1234ABCD;
    sel_man = 5'd0;
    repeat (6) @(negedge clk);
    stale_watch = 1'b1;
    sel_man = 5'd5;
    repeat (2) @(negedge clk);
    sel_man = 5'd7;
    repeat (8) @(negedge clk);
    stale_watch = 1'b0;
    check("abort_no_stale_capture", stale_hits, 0);
    check("abort_shadow_final", dut.shadow, 32'h00000007);
    expect_digit(0, 7'b1111000, 1'b1, "abort_d0_7");
    expect_digit(1, LZ_ZERO, 1'b1, "abort_d1");
    expect_digit(2, LZ_ZERO, 1'b1, "abort_d2");
    expect_digit(3, LZ_ZERO, 1'b1, "abort_d3");
    drain(24, "abort");

    // Reset asserted mid-scan
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_dispsel", dispSel, 5'd0);
    check("midrst_an", an, 4'b1111);
    check("midrst_seg", seg, 7'b1111111);
    check("midrst_dp", dp, 1'b1);
    check("midrst_shadow", dut.shadow, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_first_an", an, 4'b1110);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
